// File: rtl/qam_pkg.sv
// qam_pkg: shared helpers for the parametrised QAM modulator.
//   gray_decode  - Gray code to binary index (up to 4 bits per rail)
//   map_level    - index k to odd-integer amplitude 2k-(L-1)
//   num_levels   - L = 2^(bits_per_sym/2), levels per rail
//   level_width  - LEVEL_W = bits_per_sym/2 + 1, signed level width
//   lut_entry    - elaboration-time sine/cosine table value (real math)
package qam_pkg;

    function automatic int num_levels(input int bits_per_sym);
        return 1 << (bits_per_sym / 2);
    endfunction

    function automatic int level_width(input int bits_per_sym);
        return bits_per_sym / 2 + 1;
    endfunction

    // Binary bit i is the XOR of all Gray bits from the MSB down to i.
    function automatic int gray_decode(input logic [3:0] g, input int n);
        logic [3:0] b;
        logic       acc;
        b   = '0;
        acc = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (i < n) begin
                acc  = acc ^ g[i];
                b[i] = acc;
            end
        end
        return int'(b);
    endfunction

    function automatic int map_level(input int k, input int half);
        return 2 * k - ((1 << half) - 1);
    endfunction

    // Taylor series, valid for x in [-pi, pi]; only ever evaluated at
    // elaboration to fill the ROM constants.
    function automatic real sin_r(input real x);
        real t;
        real s;
        t = x;
        s = x;
        for (int n = 1; n < 14; n++) begin
            t = -t * x * x / real'((2 * n) * (2 * n + 1));
            s = s + t;
        end
        return s;
    endfunction

    function automatic int lut_entry(input int addr, input int addr_w,
                                     input int sample_w, input bit is_cos);
        real pi_c;
        real ang;
        real amp;
        real v;
        pi_c = 3.14159265358979323846;
        ang  = 2.0 * pi_c * real'(addr) / real'(1 << addr_w);
        if (is_cos) ang = ang + pi_c / 2.0;
        if (ang > pi_c) ang = ang - 2.0 * pi_c;
        amp = real'((1 << (sample_w - 1)) - 1);
        v   = amp * sin_r(ang);
        // Round half away from zero.
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

endpackage

// File: rtl/qam_sincos_lut.sv
// qam_sincos_lut: registered dual-output sine/cosine ROM, one cycle latency.
//   clk     - clock, rising edge
//   rst     - synchronous active-low reset, clears both outputs
//   addr    - table address (phase)
//   sin_out - round(A*sin(2*pi*addr/2^ADDR_W)), A = 2^(SAMPLE_W-1)-1
//   cos_out - same for cosine
module qam_sincos_lut
    import qam_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int SAMPLE_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          addr,
    output logic signed [SAMPLE_W-1:0] sin_out,
    output logic signed [SAMPLE_W-1:0] cos_out
);

    logic signed [SAMPLE_W-1:0] sin_rom [2**ADDR_W];
    logic signed [SAMPLE_W-1:0] cos_rom [2**ADDR_W];

    // Table contents are constants computed at elaboration.
    for (genvar a = 0; a < 2**ADDR_W; a++) begin : g_rom
        localparam int SIN_V = lut_entry(a, ADDR_W, SAMPLE_W, 1'b0);
        localparam int COS_V = lut_entry(a, ADDR_W, SAMPLE_W, 1'b1);
        assign sin_rom[a] = SAMPLE_W'(SIN_V);
        assign cos_rom[a] = SAMPLE_W'(COS_V);
    end

    logic signed [SAMPLE_W-1:0] sin_d, sin_q, cos_d, cos_q;

    always_comb begin
        sin_d = sin_rom[addr];
        cos_d = cos_rom[addr];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sin_q <= '0;
            cos_q <= '0;
        end else begin
            sin_q <= sin_d;
            cos_q <= cos_d;
        end
    end

    assign sin_out = sin_q;
    assign cos_out = cos_q;

endmodule

// File: rtl/qam_mod_param.sv
// qam_mod_param: parametrised M-QAM modulator with internal NCO carrier.
//   clk, rst            - clock; synchronous active-low reset
//   bit_in, bit_valid   - serial input, MSB of each symbol first
//   bit_ready           - input can take a bit this cycle
//   parallel            - symbol currently being transmitted
//   sym_strobe          - one-cycle pulse when a new symbol goes on air
//   sampled_sine_test   - registered sine sample
//   sampled_cosine_test - registered cosine sample
//   mixed_signal        - (aI*cos - aQ*sin) >>> (BITS_PER_SYM/2+1)
//   underrun            - one-cycle pulse: boundary without a full symbol
module qam_mod_param
    import qam_pkg::*;
#(
    parameter int               BITS_PER_SYM    = 2,
    parameter int               SAMPLES_PER_SYM = 16,
    parameter int               SAMPLE_W        = 16,
    parameter int               ACC_W           = 32,
    parameter int               LUT_ADDR_W      = 8,
    parameter logic [ACC_W-1:0] PHASE_INC       = ACC_W'(2**24)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bit_in,
    input  logic                       bit_valid,
    output logic                       bit_ready,
    output logic [BITS_PER_SYM-1:0]    parallel,
    output logic                       sym_strobe,
    output logic signed [SAMPLE_W-1:0] sampled_sine_test,
    output logic signed [SAMPLE_W-1:0] sampled_cosine_test,
    output logic signed [SAMPLE_W-1:0] mixed_signal,
    output logic                       underrun
);

    localparam int HALF    = BITS_PER_SYM / 2;
    localparam int LEVEL_W = level_width(BITS_PER_SYM);
    localparam int CNT_W   = $clog2(BITS_PER_SYM + 1);
    localparam int SCNT_W  = $clog2(SAMPLES_PER_SYM);
    localparam int PROD_W  = SAMPLE_W + LEVEL_W;

    logic [ACC_W-1:0]          phase_d, phase_q;
    logic [SCNT_W-1:0]         scnt_d, scnt_q;
    logic [CNT_W-1:0]          cnt_d, cnt_q;
    logic [BITS_PER_SYM-1:0]   coll_d, coll_q;
    logic [BITS_PER_SYM-1:0]   par_d, par_q;
    logic signed [LEVEL_W-1:0] ai_d, ai_q, aq_d, aq_q;
    logic signed [LEVEL_W-1:0] ai1_d, ai1_q, aq1_d, aq1_q;
    logic                      strobe_d, strobe_q, under_d, under_q;
    logic signed [SAMPLE_W-1:0] mixed_d, mixed_q;

    logic signed [SAMPLE_W-1:0] sin_s, cos_s;
    logic signed [LEVEL_W-1:0]  lvl_i, lvl_q;
    logic signed [PROD_W-1:0]   prod_i, prod_q;
    logic signed [PROD_W:0]     diff;
    logic                       boundary, full;

    qam_sincos_lut #(
        .ADDR_W  (LUT_ADDR_W),
        .SAMPLE_W(SAMPLE_W)
    ) u_lut (
        .clk    (clk),
        .rst    (rst),
        .addr   (phase_q[ACC_W-1 -: LUT_ADDR_W]),
        .sin_out(sin_s),
        .cos_out(cos_s)
    );

    // Handshake: a bit transfers on a cycle where bit_valid && bit_ready;
    // bit_ready depends only on internal state (and reset), never on
    // bit_valid, and stays low while the collector holds a full symbol.
    assign bit_ready = rst & (cnt_q < CNT_W'(BITS_PER_SYM));

    assign boundary = (scnt_q == SCNT_W'(SAMPLES_PER_SYM - 1));
    assign full     = (cnt_q == CNT_W'(BITS_PER_SYM));

    always_comb begin
        lvl_i = LEVEL_W'(map_level(
            gray_decode(4'(coll_q[BITS_PER_SYM-1 -: HALF]), HALF), HALF));
        lvl_q = LEVEL_W'(map_level(
            gray_decode(4'(coll_q[HALF-1:0]), HALF), HALF));
    end

    always_comb begin
        phase_d  = phase_q + PHASE_INC;
        scnt_d   = boundary ? '0 : scnt_q + SCNT_W'(1);
        cnt_d    = cnt_q;
        coll_d   = coll_q;
        par_d    = par_q;
        ai_d     = ai_q;
        aq_d     = aq_q;
        strobe_d = 1'b0;
        under_d  = 1'b0;

        // New levels take effect on the first sample of the next period,
        // the same cycle the carrier phase for that sample is registered.
        if (boundary) begin
            if (full) begin
                ai_d     = lvl_i;
                aq_d     = lvl_q;
                par_d    = coll_q;
                cnt_d    = '0;
                strobe_d = 1'b1;
            end else begin
                ai_d    = '0;
                aq_d    = '0;
                under_d = 1'b1;
            end
        end

        // Never coincides with a load: bit_ready is low when full.
        if (bit_valid && bit_ready) begin
            coll_d = {coll_q[BITS_PER_SYM-2:0], bit_in};
            cnt_d  = cnt_q + CNT_W'(1);
        end

        // Stage 1 delays the levels to line up with the LUT output.
        ai1_d = ai_q;
        aq1_d = aq_q;

        prod_i  = PROD_W'(ai1_q) * PROD_W'(cos_s);
        prod_q  = PROD_W'(aq1_q) * PROD_W'(sin_s);
        diff    = (PROD_W + 1)'(prod_i) - (PROD_W + 1)'(prod_q);
        // Scaled result always fits SAMPLE_W, so plain truncation.
        mixed_d = SAMPLE_W'(diff >>> LEVEL_W);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q  <= '0;
            scnt_q   <= '0;
            cnt_q    <= '0;
            coll_q   <= '0;
            par_q    <= '0;
            ai_q     <= '0;
            aq_q     <= '0;
            ai1_q    <= '0;
            aq1_q    <= '0;
            strobe_q <= 1'b0;
            under_q  <= 1'b0;
            mixed_q  <= '0;
        end else begin
            phase_q  <= phase_d;
            scnt_q   <= scnt_d;
            cnt_q    <= cnt_d;
            coll_q   <= coll_d;
            par_q    <= par_d;
            ai_q     <= ai_d;
            aq_q     <= aq_d;
            ai1_q    <= ai1_d;
            aq1_q    <= aq1_d;
            strobe_q <= strobe_d;
            under_q  <= under_d;
            mixed_q  <= mixed_d;
        end
    end

    assign parallel            = par_q;
    assign sym_strobe          = strobe_q;
    assign underrun            = under_q;
    assign sampled_sine_test   = sin_s;
    assign sampled_cosine_test = cos_s;
    assign mixed_signal        = mixed_q;

endmodule

// File: tb/tb_qam_mod_param.sv
// tb_qam_mod_param: bench for qam_mod_param (QPSK and 16-QAM instances).
module tb_qam_mod_param;

    localparam int SPS = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic v2, b2, v4, b4;
    logic rdy2, rdy4, stb2, stb4, und2, und4;
    logic [1:0] par2;
    logic [3:0] par4;
    logic signed [15:0] sin2, cos2, mix2, sin4, cos4, mix4;

    qam_mod_param #(.BITS_PER_SYM(2)) dut2 (
        .clk(clk), .rst(rst), .bit_in(b2), .bit_valid(v2), .bit_ready(rdy2),
        .parallel(par2), .sym_strobe(stb2), .sampled_sine_test(sin2),
        .sampled_cosine_test(cos2), .mixed_signal(mix2), .underrun(und2)
    );

    qam_mod_param #(.BITS_PER_SYM(4)) dut4 (
        .clk(clk), .rst(rst), .bit_in(b4), .bit_valid(v4), .bit_ready(rdy4),
        .parallel(par4), .sym_strobe(stb4), .sampled_sine_test(sin4),
        .sampled_cosine_test(cos4), .mixed_signal(mix4), .underrun(und4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (QPSK instance) ----------------
    function automatic int ref_round(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    function automatic int ref_sin(input int a);
        return ref_round(32767.0 * $sin(2.0 * 3.14159265358979323846 * a / 256.0));
    endfunction

    function automatic int ref_cos(input int a);
        return ref_round(32767.0 * $cos(2.0 * 3.14159265358979323846 * a / 256.0));
    endfunction

    // Find k whose Gray code equals the received bits, then 2k-(L-1).
    function automatic int ref_level(input int bits, input int half);
        int l;
        l = 1 << half;
        for (int k = 0; k < l; k++)
            if ((k ^ (k >> 1)) == bits) return 2 * k - (l - 1);
        return 0;
    endfunction

    function automatic int floor_div(input int num, input int d);
        if (num >= 0) return num / d;
        return -((-num + d - 1) / d);
    endfunction

    int m_j, m_par, m_ai, m_aq, p1_ai, p1_aq, p1_addr;
    int m_bits[$];
    logic [1:0] exp_q[$];

    task automatic model_reset();
        m_j = 0; m_par = 0; m_ai = 0; m_aq = 0;
        p1_ai = 0; p1_aq = 0; p1_addr = 0;
        m_bits.delete();
        exp_q.delete();
    endtask

    // One clock of the QPSK instance with model checking.
    task automatic step2(input logic v, input logic b, input logic r);
        int exp_rdy, e_stb, e_und, e_mix, n_ai, n_aq, sym;
        logic acc;
        rst = r; v2 = v; b2 = b; v4 = 1'b0; b4 = 1'b0;
        #1;
        exp_rdy = (r && m_bits.size() < 2) ? 1 : 0;
        chk("bit_ready", int'(rdy2), exp_rdy);
        acc = v && (exp_rdy == 1);
        @(posedge clk);
        #1;
        if (!r) begin
            model_reset();
            chk("rst_parallel", int'(par2), 0);
            chk("rst_strobe", int'(stb2), 0);
            chk("rst_underrun", int'(und2), 0);
            chk("rst_sin", int'(sin2), 0);
            chk("rst_cos", int'(cos2), 0);
            chk("rst_mixed", int'(mix2), 0);
            return;
        end
        e_stb = 0; e_und = 0; n_ai = m_ai; n_aq = m_aq;
        if (m_j % SPS == SPS - 1) begin
            if (m_bits.size() == 2) begin
                sym = m_bits[0] * 2 + m_bits[1];
                m_par = sym;
                e_stb = 1;
                n_ai = ref_level(sym >> 1, 1);
                n_aq = ref_level(sym & 1, 1);
                m_bits.delete();
                exp_q.push_back(2'(sym));
            end else begin
                e_und = 1; n_ai = 0; n_aq = 0;
            end
        end
        if (acc) m_bits.push_back(int'(b));
        e_mix = floor_div(p1_ai * ref_cos(p1_addr) - p1_aq * ref_sin(p1_addr), 4);
        chk("cos", int'(cos2), ref_cos(m_j % 256));
        chk("sin", int'(sin2), ref_sin(m_j % 256));
        chk("mixed", int'(mix2), e_mix);
        chk("sym_strobe", int'(stb2), e_stb);
        chk("underrun", int'(und2), e_und);
        chk("parallel", int'(par2), m_par);
        if (stb2) begin
            chk("sym_queue_nonempty", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("sym_order", int'(par2), int'(exp_q.pop_front()));
        end
        p1_ai = m_ai; p1_aq = m_aq; p1_addr = m_j % 256;
        m_ai = n_ai; m_aq = n_aq;
        m_j++;
    endtask

    // ---------------- directed table (both instances) ----------------
    typedef struct {
        int         p;     // symbol period; its first sample has addr 16p mod 256
        logic [1:0] s2;
        logic [3:0] s4;
        int         e2;    // expected first-sample mixed, QPSK
        int         e4;    // expected first-sample mixed, 16-QAM
    } vec_t;

    vec_t tbl[6];

    task automatic run_table();
        int hit, s, q;
        logic [1:0] t2;
        logic [3:0] t4;
        rst = 1'b0; v2 = 1'b0; b2 = 1'b0; v4 = 1'b0; b4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int j = 0; j < 16 * 24 + 2; j++) begin
            q = j / SPS;
            s = j % SPS;
            hit = -1;
            for (int k = 0; k < 6; k++) if (tbl[k].p == q + 1) hit = k;
            v2 = 1'b0; b2 = 1'b0; v4 = 1'b0; b4 = 1'b0;
            if (hit >= 0) begin
                t2 = tbl[hit].s2;
                t4 = tbl[hit].s4;
                if (s < 2) begin v2 = 1'b1; b2 = t2[1 - s]; end
                if (s < 4) begin v4 = 1'b1; b4 = t4[3 - s]; end
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < 6; k++) begin
                if (j == 16 * tbl[k].p - 1) begin
                    chk("tbl_strobe2", int'(stb2), 1);
                    chk("tbl_strobe4", int'(stb4), 1);
                end
                if (j == 16 * tbl[k].p + 1) begin
                    chk("tbl_mixed2", int'(mix2), tbl[k].e2);
                    chk("tbl_mixed4", int'(mix4), tbl[k].e4);
                    chk("tbl_parallel2", int'(par2), int'(tbl[k].s2));
                    chk("tbl_parallel4", int'(par4), int'(tbl[k].s4));
                end
            end
        end
    endtask

    task automatic run_random(input int cycles);
        int dens;
        dens = 2;
        for (int i = 0; i < cycles; i++) begin
            if (i % 100 == 0) dens = $urandom_range(0, 4);
            step2(($urandom_range(0, 3) < dens) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)), 1'b1);
        end
    endtask

    initial begin
        tbl[0] = '{p: 4,  s2: 2'b00, s4: 4'b1110, e2: 8191,  e4: -12288};
        tbl[1] = '{p: 8,  s2: 2'b11, s4: 4'b1110, e2: -8192, e4: -4096};
        tbl[2] = '{p: 12, s2: 2'b11, s4: 4'b1110, e2: 8191,  e4: 12287};
        tbl[3] = '{p: 16, s2: 2'b00, s4: 4'b1110, e2: -8192, e4: 4095};
        tbl[4] = '{p: 20, s2: 2'b01, s4: 4'b0000, e2: -8192, e4: 12287};
        tbl[5] = '{p: 24, s2: 2'b10, s4: 4'b0101, e2: -8192, e4: 4095};

        rst = 1'b0; v2 = 1'b0; b2 = 1'b0; v4 = 1'b0; b4 = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset then idle: underrun every period, silence, carrier runs.
        repeat (10) step2(1'b0, 1'b0, 1'b0);
        repeat (48) step2(1'b0, 1'b0, 1'b1);

        run_table();

        // Backpressure: valid held high.
        repeat (2) step2(1'b0, 1'b0, 1'b0);
        repeat (40) step2(1'b1, 1'($urandom_range(0, 1)), 1'b1);

        // Partial symbol stalled across a boundary, then completed.
        repeat (20) step2(1'b0, 1'b0, 1'b1);
        step2(1'b1, 1'b1, 1'b1);
        repeat (20) step2(1'b0, 1'b0, 1'b1);
        step2(1'b1, 1'b0, 1'b1);
        repeat (20) step2(1'b0, 1'b0, 1'b1);

        run_random(1200);

        // Reset in the middle of symbol 3.
        repeat (2) step2(1'b0, 1'b0, 1'b0);
        while (m_j != 16 * 3 + 5) step2(1'b1, 1'($urandom_range(0, 1)), 1'b1);
        repeat (2) step2(1'b1, 1'b1, 1'b0);
        run_random(400);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
